// File: rtl/div_ctrl.sv
// Sequencing controller for the M-extension divide lane, plus the pipelined divider it drives.
// Optional macro DIV_CTRL_FAST_SPECIAL_EN adds a 1-cycle bypass for divide-by-zero/overflow.

module divfunc #(
  parameter int          XLEN       = 32,
  parameter logic [31:0] STAGE_LIST = 32'h0000_0007
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            vld,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            ack,
  output logic [XLEN-1:0] quo,
  output logic [XLEN-1:0] rem
);

  function automatic int count_stages(input logic [31:0] s);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) n += int'(s[i]);
    return n;
  endfunction

  localparam int LAT = count_stages(STAGE_LIST);

  logic [XLEN:0]                part;
  logic [XLEN-1:0]              q_c, r_c;
  logic [LAT-1:0]               vld_q, vld_d;
  logic [LAT-1:0][XLEN-1:0]     quo_q, quo_d, rem_q, rem_d;

  // Restoring division; b == 0 naturally yields all-ones quotient and remainder a.
  always_comb begin
    q_c  = '0;
    part = '0;
    for (int i = XLEN - 1; i >= 0; i--) begin
      part = {part[XLEN-1:0], a[i]};
      if (part >= {1'b0, b}) begin
        part   = part - {1'b0, b};
        q_c[i] = 1'b1;
      end
    end
    r_c = part[XLEN-1:0];
  end

  // Stage positions only set the register count here; all stages sit after the array.
  always_comb begin
    vld_d = vld_q;
    quo_d = quo_q;
    rem_d = rem_q;
    if (!stall) begin
      vld_d[0] = vld;
      quo_d[0] = q_c;
      rem_d[0] = r_c;
      for (int k = 1; k < LAT; k++) begin
        vld_d[k] = vld_q[k-1];
        quo_d[k] = quo_q[k-1];
        rem_d[k] = rem_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
    end else begin
      vld_q <= vld_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
    end
  end

  assign ack = vld_q[LAT-1];
  assign quo = quo_q[LAT-1];
  assign rem = rem_q[LAT-1];

endmodule

module div_ctrl #(
  parameter int          XLEN       = 32,
  parameter logic [31:0] STAGE_LIST = 32'h0000_0007,
  parameter int          TAG_W      = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [TAG_W-1:0] out_tag
);

  function automatic int count_stages(input logic [31:0] s);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) n += int'(s[i]);
    return n;
  endfunction

  localparam int LAT = count_stages(STAGE_LIST);

  if (LAT < 1) begin : g_lat_check
    $error("div_ctrl: STAGE_LIST must register at least one divider stage");
  end

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [1:0]       op;
    logic             neg_q;
    logic             neg_r;
    logic             dz;
    logic [XLEN-1:0]  rs1;
  } meta_t;

  meta_t [LAT-1:0]  meta_q, meta_d;
  meta_t            head, new_meta;
  logic             is_signed, accept, take_byp, byp_busy, stall;
  logic             div_vld, div_ack, res_valid;
  logic [XLEN-1:0]  div_a, div_b, quo, rem, fix_q, fix_r, pipe_data, res_data;
  logic [TAG_W-1:0] res_tag;

  assign head = meta_q[LAT-1];

  always_comb begin
    is_signed      = ~in_op[0];
    div_a          = (is_signed && in_rs1[XLEN-1]) ? -in_rs1 : in_rs1;
    div_b          = (is_signed && in_rs2[XLEN-1]) ? -in_rs2 : in_rs2;
    new_meta.valid = div_vld;
    new_meta.tag   = in_tag;
    new_meta.op    = in_op;
    new_meta.neg_q = is_signed & (in_rs1[XLEN-1] ^ in_rs2[XLEN-1]);
    new_meta.neg_r = is_signed & in_rs1[XLEN-1];
    new_meta.dz    = (in_rs2 == '0);
    new_meta.rs1   = in_rs1;
  end

  divfunc #(
    .XLEN       (XLEN),
    .STAGE_LIST (STAGE_LIST)
  ) u_divfunc (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .vld   (div_vld),
    .a     (div_a),
    .b     (div_b),
    .ack   (div_ack),
    .quo   (quo),
    .rem   (rem)
  );

  // Overflow (INT_MIN / -1) needs no special case: |a|/|b| gives 0x8000_0000 rem 0, unsigned.
  always_comb begin
    fix_q = head.neg_q ? -quo : quo;
    fix_r = head.neg_r ? -rem : rem;
    if (head.dz) begin
      fix_q = '1;
      fix_r = head.rs1;
    end
    pipe_data = head.op[1] ? fix_r : fix_q;
  end

`ifdef DIV_CTRL_FAST_SPECIAL_EN
  localparam logic [XLEN-1:0] IntMin = {1'b1, {(XLEN-1){1'b0}}};

  logic             special, pipe_empty, byp_valid_q, byp_valid_d;
  logic [XLEN-1:0]  byp_data_q, byp_data_d;
  logic [TAG_W-1:0] byp_tag_q, byp_tag_d;

  always_comb begin
    special    = (in_rs2 == '0) | (~in_op[0] & (in_rs1 == IntMin) & (&in_rs2));
    pipe_empty = 1'b1;
    for (int k = 0; k < LAT; k++) begin
      if (meta_q[k].valid) pipe_empty = 1'b0;
    end
  end

  // Only bypass into an empty pipe so results stay in issue order.
  assign take_byp = accept & special & pipe_empty;
  assign byp_busy = byp_valid_q;

  always_comb begin
    byp_valid_d = byp_valid_q;
    byp_data_d  = byp_data_q;
    byp_tag_d   = byp_tag_q;
    if (byp_valid_q && out_ready) byp_valid_d = 1'b0;
    if (take_byp) begin
      byp_valid_d = 1'b1;
      byp_tag_d   = in_tag;
      if (in_rs2 == '0) byp_data_d = in_op[1] ? in_rs1 : '1;
      else              byp_data_d = in_op[1] ? '0 : IntMin;
    end
    if (flush) byp_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byp_valid_q <= 1'b0;
      byp_data_q  <= '0;
      byp_tag_q   <= '0;
    end else begin
      byp_valid_q <= byp_valid_d;
      byp_data_q  <= byp_data_d;
      byp_tag_q   <= byp_tag_d;
    end
  end

  assign res_valid = byp_valid_q | head.valid;
  assign res_data  = byp_valid_q ? byp_data_q : pipe_data;
  assign res_tag   = byp_valid_q ? byp_tag_q : head.tag;
`else
  assign take_byp  = 1'b0;
  assign byp_busy  = 1'b0;
  assign res_valid = head.valid;
  assign res_data  = pipe_data;
  assign res_tag   = head.tag;
`endif

  // Gating with rst keeps any pre-reset result off the port during the reset cycle.
  assign out_valid = res_valid & ~rst;
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall & ~flush & ~byp_busy;
  assign accept    = in_valid & in_ready;
  assign div_vld   = accept & ~take_byp;
  assign out_data  = out_valid ? res_data : '0;
  assign out_tag   = out_valid ? res_tag : '0;

  always_comb begin
    meta_d = meta_q;
    if (!stall) begin
      meta_d[0] = new_meta;
      for (int k = 1; k < LAT; k++) meta_d[k] = meta_q[k-1];
    end
    if (flush) begin
      for (int k = 0; k < LAT; k++) meta_d[k].valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) meta_q <= '0;
    else     meta_q <= meta_d;
  end

  // The divider is never flushed, so a live metadata entry always has divider data beside it.
  meta_ack_a: assert property (@(posedge clk) disable iff (rst) head.valid |-> div_ack);
  unsigned_sign_a: assert property (@(posedge clk) disable iff (rst)
                                    (head.valid && head.op[0]) |-> !(head.neg_q || head.neg_r));

endmodule
